// File: rtl/clause_pkg.sv
// Shared definitions for the clause scan path: default geometry, the
// literal/clause/row layout and the scan sequencer state encoding.
package clause_pkg;

   localparam int unsigned NUM_CLAUSES           = 64;
   localparam int unsigned VAR_ID_BITS           = 8;
   localparam int unsigned NUM_CLAUSES_PER_CYCLE = 16;
   localparam int unsigned NUM_VARS_PER_CLAUSE   = 3;

   localparam int unsigned LIT_WIDTH = VAR_ID_BITS + 1;
   localparam int unsigned ROW_WIDTH = LIT_WIDTH * NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE;
   localparam int unsigned NUM_ROWS  = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;

   // One literal: variable id followed by its negation flag.
   typedef struct packed {
      logic [VAR_ID_BITS-1:0] var_id;
      logic                   neg;
   } literal_t;

   typedef literal_t [NUM_VARS_PER_CLAUSE-1:0]   clause_t;
   typedef clause_t  [NUM_CLAUSES_PER_CYCLE-1:0] clause_row_t;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } scan_state_t;

endpackage

// File: rtl/clause_slice_reg.sv
// One-entry valid/ready output register carrying a clause row and its
// row index. A load may coincide with the current entry being accepted.
module clause_slice_reg #(
   parameter int unsigned DATA_WIDTH = clause_pkg::ROW_WIDTH,
   parameter int unsigned ROW_BITS   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic [ROW_BITS-1:0]   load_row,
   output logic                  valid,
   input  logic                  ready,
   output logic [DATA_WIDTH-1:0] data,
   output logic [ROW_BITS-1:0]   row
);

   // Hold the entry until accepted; a load replaces it, otherwise acceptance empties it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         row   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         row   <= load_row;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/clause_scan_controller.sv
// Clause scan sequencer: walks every clause-memory row once per pass,
// hands rows to the evaluator, counts returning results and reports
// satisfiability with a one-cycle done pulse.
// Optional build macro: CLAUSE_SCAN_EARLY_ABORT_EN stops issuing rows
// on the first unsatisfied result seen while scanning.
module clause_scan_controller #(
   parameter int unsigned NUM_CLAUSES           = 64,
   parameter int unsigned VAR_ID_BITS           = 8,
   parameter int unsigned NUM_CLAUSES_PER_CYCLE = 16,
   parameter int unsigned NUM_VARS_PER_CLAUSE   = 3,
   parameter int unsigned PTR_BITS              = $clog2(NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE),
   localparam int unsigned ROW_WIDTH = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
   localparam int unsigned NUM_ROWS  = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [PTR_BITS-1:0]  row_ptr,
   input  logic [ROW_WIDTH-1:0] mem_slice,
   output logic [ROW_WIDTH-1:0] slice_data,
   output logic [PTR_BITS-1:0]  slice_row,
   output logic                 slice_valid,
   input  logic                 slice_ready,
   input  logic                 res_valid,
   input  logic                 res_unsat,
   output logic                 busy,
   output logic                 done,
   output logic                 sat
);

   import clause_pkg::*;

   localparam logic [PTR_BITS-1:0] LAST_ROW = PTR_BITS'(NUM_ROWS - 1);

   scan_state_t         state;
   scan_state_t         state_next;
   logic [PTR_BITS:0]   out_cnt;
   logic                unsat_seen;
   logic                handshake;
   logic                res_accept;
   logic                abort;
   logic                load;
   logic                start_pass;
   logic                sat_update;

   assign handshake = slice_valid & slice_ready;
   // A result is legitimate if a row is outstanding or is being handed over right now.
   assign res_accept = res_valid & ((out_cnt != '0) | handshake);

`ifdef CLAUSE_SCAN_EARLY_ABORT_EN
   assign abort = res_accept & res_unsat;
`else
   assign abort = 1'b0;
`endif

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   clause_slice_reg #(
      .DATA_WIDTH (ROW_WIDTH),
      .ROW_BITS   (PTR_BITS)
   ) u_slice_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (mem_slice),
      .load_row  (row_ptr),
      .valid     (slice_valid),
      .ready     (slice_ready),
      .data      (slice_data),
      .row       (slice_row)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control decode; an abort blocks the load in the same cycle.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      start_pass = 1'b0;
      sat_update = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_pass = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               state_next = DRAIN;
            end else if (!slice_valid || slice_ready) begin
               load = 1'b1;
               if (row_ptr == LAST_ROW) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!slice_valid && (out_cnt == '0)) begin
               sat_update = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Row pointer, outstanding-result count, unsat tracking and the pass result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_ptr    <= '0;
         out_cnt    <= '0;
         unsat_seen <= 1'b0;
         sat        <= 1'b0;
      end else if (start_pass) begin
         row_ptr    <= '0;
         out_cnt    <= '0;
         unsat_seen <= 1'b0;
         sat        <= 1'b0;
      end else begin
         if (load) begin
            row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
         end
         if (handshake && !res_accept) begin
            out_cnt <= out_cnt + 1'b1;
         end else if (!handshake && res_accept) begin
            out_cnt <= out_cnt - 1'b1;
         end
         if (res_accept && res_unsat) begin
            unsat_seen <= 1'b1;
         end
         if (sat_update) begin
            sat <= !unsat_seen;
         end
      end
   end

endmodule

// File: tb/tb_clause_scan_controller.sv
// Randomized self-checking bench for clause_scan_controller. A queue-based
// reference tracks issued rows and in-order results and predicts row order,
// row data, pass result and done timing.
module tb_clause_scan_controller;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned PTR_BITS = 2;
   localparam int unsigned ROW_W    = 9 * 3 * 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [PTR_BITS-1:0] row_ptr;
   logic [ROW_W-1:0]    mem_slice;
   logic [ROW_W-1:0]    slice_data;
   logic [PTR_BITS-1:0] slice_row;
   logic                slice_valid;
   logic                slice_ready;
   logic                res_valid;
   logic                res_unsat;
   logic                busy;
   logic                done;
   logic                sat;

   logic [ROW_W-1:0]    mem [NUM_ROWS];
   int                  n_checks = 0;
   int                  n_pass   = 0;

   assign mem_slice = mem[row_ptr];

   clause_scan_controller #(
      .NUM_CLAUSES           (64),
      .VAR_ID_BITS           (8),
      .NUM_CLAUSES_PER_CYCLE (16),
      .NUM_VARS_PER_CLAUSE   (3),
      .PTR_BITS              (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .row_ptr     (row_ptr),
      .mem_slice   (mem_slice),
      .slice_data  (slice_data),
      .slice_row   (slice_row),
      .slice_valid (slice_valid),
      .slice_ready (slice_ready),
      .res_valid   (res_valid),
      .res_unsat   (res_unsat),
      .busy        (busy),
      .done        (done),
      .sat         (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic fill_mem();
      for (int r = 0; r < NUM_ROWS; r++) begin
         for (int b = 0; b < ROW_W; b++) begin
            mem[r][b] = 1'($urandom_range(1, 0));
         end
      end
   endtask

   // Runs one pass; entered and left at #1 after a rising edge.
   // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
   task automatic run_pass(input string name, input int rmode, input int lat_lo, input int lat_hi,
                           input logic [NUM_ROWS-1:0] unsat_mask, input bit timed, input bit poke);
      int cyc;
      int exp_idx;
      int last_res;
      int last_due;
      int lat;
      int due_q[$];
      int row_q[$];
      bit any_unsat;
      bit got_done;
      bit stalled;
      bit hs;
      logic [ROW_W-1:0]    hold_d;
      logic [PTR_BITS-1:0] hold_r;
      cyc = 0; exp_idx = 0; last_res = -100; last_due = 0;
      any_unsat = 1'b0; got_done = 1'b0; stalled = 1'b0;
      hold_d = '0; hold_r = '0;
      start = 1'b1; slice_ready = 1'b0; res_valid = 1'b0; res_unsat = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      check({name, ":busy_scan"}, ROW_W'(busy), ROW_W'(1));
      while (!got_done && cyc < 300) begin
         if (stalled) begin
            check({name, ":stall_valid"}, ROW_W'(slice_valid), ROW_W'(1));
            check({name, ":stall_row"}, ROW_W'(slice_row), ROW_W'(hold_r));
            check({name, ":stall_data"}, slice_data, hold_d);
         end
         if (done) begin
            got_done = 1'b1;
            stalled  = 1'b0;
            check({name, ":done_cyc"}, ROW_W'(cyc), ROW_W'(last_res + 2));
            check({name, ":sat"}, ROW_W'(sat), ROW_W'(!any_unsat));
`ifdef CLAUSE_SCAN_EARLY_ABORT_EN
            if (unsat_mask == '0) begin
               check({name, ":rows"}, ROW_W'(exp_idx), ROW_W'(NUM_ROWS));
            end else if (timed) begin
               int first_bad;
               first_bad = 0;
               for (int k = NUM_ROWS - 1; k >= 0; k--) if (unsat_mask[k]) first_bad = k;
               check({name, ":rows_abort"}, ROW_W'(exp_idx), ROW_W'(first_bad + 1));
            end
            if (timed && !any_unsat) begin
               check({name, ":latency"}, ROW_W'(cyc), ROW_W'(NUM_ROWS + 3));
            end
`else
            check({name, ":rows"}, ROW_W'(exp_idx), ROW_W'(NUM_ROWS));
            if (timed) begin
               check({name, ":latency"}, ROW_W'(cyc), ROW_W'(NUM_ROWS + 3));
            end
`endif
            start       = poke;
            slice_ready = 1'b0;
            res_valid   = 1'b0;
            res_unsat   = 1'b0;
         end else begin
            start = (poke && cyc == 3);
            case (rmode)
               0:       slice_ready = 1'b1;
               1:       slice_ready = ((cyc % 3) == 1);
               default: slice_ready = 1'($urandom_range(1, 0));
            endcase
            hs      = slice_valid && slice_ready;
            stalled = slice_valid && !slice_ready;
            hold_d  = slice_data;
            hold_r  = slice_row;
            if (hs) begin
               check({name, ":row"}, ROW_W'(slice_row), ROW_W'(exp_idx));
               check({name, ":data"}, slice_data, mem[exp_idx % NUM_ROWS]);
               if (timed) begin
                  check({name, ":row_cyc"}, ROW_W'(cyc), ROW_W'(exp_idx + 2));
               end
               lat = $urandom_range(lat_hi, lat_lo);
               if (cyc + lat > last_due) last_due = cyc + lat;
               due_q.push_back(last_due);
               row_q.push_back(exp_idx);
               exp_idx++;
            end
            res_valid = 1'b0;
            res_unsat = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
               res_valid = 1'b1;
               res_unsat = unsat_mask[row_q[0] % NUM_ROWS];
               any_unsat = any_unsat | res_unsat;
               void'(due_q.pop_front());
               void'(row_q.pop_front());
               last_res = cyc;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      check({name, ":finished"}, ROW_W'(got_done), ROW_W'(1));
      start = 1'b0;
      check({name, ":done_pulse"}, ROW_W'(done), ROW_W'(0));
      check({name, ":idle_after"}, ROW_W'(busy), ROW_W'(0));
      check({name, ":sat_hold"}, ROW_W'(sat), ROW_W'(!any_unsat));
   endtask

   task automatic reset_mid_pass();
      int guard;
      guard = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      slice_ready = 1'b1;
      while (!(slice_valid && slice_row == 2'd2) && guard < 20) begin
         res_valid = slice_valid;
         res_unsat = 1'b0;
         @(posedge clk); #1;
         guard++;
      end
      check("rst:row2_pending", ROW_W'(slice_row), ROW_W'(2));
      slice_ready = 1'b0;
      res_valid   = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst:slice_valid", ROW_W'(slice_valid), ROW_W'(0));
      check("rst:row_ptr", ROW_W'(row_ptr), ROW_W'(0));
      check("rst:slice_row", ROW_W'(slice_row), ROW_W'(0));
      check("rst:slice_data", slice_data, ROW_W'(0));
      check("rst:busy", ROW_W'(busy), ROW_W'(0));
      check("rst:done", ROW_W'(done), ROW_W'(0));
      check("rst:sat", ROW_W'(sat), ROW_W'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; slice_ready = 1'b0; res_valid = 1'b0; res_unsat = 1'b0;
      fill_mem();
      repeat (3) @(posedge clk);
      #1;
      check("reset:row_ptr", ROW_W'(row_ptr), ROW_W'(0));
      check("reset:slice_valid", ROW_W'(slice_valid), ROW_W'(0));
      check("reset:slice_row", ROW_W'(slice_row), ROW_W'(0));
      check("reset:slice_data", slice_data, ROW_W'(0));
      check("reset:busy", ROW_W'(busy), ROW_W'(0));
      check("reset:done", ROW_W'(done), ROW_W'(0));
      check("reset:sat", ROW_W'(sat), ROW_W'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      run_pass("basic", 0, 0, 0, 4'b0000, 1'b1, 1'b0);
      run_pass("unsat2", 0, 0, 0, 4'b0100, 1'b1, 1'b0);
      run_pass("stall", 1, 0, 0, 4'b0000, 1'b0, 1'b0);
      run_pass("lat5", 0, 5, 5, 4'b0000, 1'b0, 1'b0);
      run_pass("poke", 2, 0, 3, 4'b0000, 1'b0, 1'b1);

      res_valid = 1'b1;
      res_unsat = 1'b1;
      @(posedge clk); #1;
      res_valid = 1'b0;
      res_unsat = 1'b0;
      check("spurious:busy", ROW_W'(busy), ROW_W'(0));
      check("spurious:done", ROW_W'(done), ROW_W'(0));

      reset_mid_pass();
      run_pass("post_rst", 0, 0, 0, 4'b0000, 1'b1, 1'b0);

      for (int i = 0; i < 12; i++) begin
         fill_mem();
         run_pass("rand", 2, 0, 4, 4'($urandom_range(15, 0)), 1'b0, 1'(i % 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
